// File: rtl/regfile_np.sv
// ---------------------------------------------------------------------------
// regfile_np -- parametrised integer register file for the rv32 pipeline.
//
// NRD registered read ports and one write port, all on the rising edge of clk.
// Features: write-first bypass into the read ports, optional hardwired zero
// register, per-port read enables, synchronous clear, and a per-register
// pending-write (busy) scoreboard used by decode for RAW hazard detection.
//
// Parameters:
//   XLEN     register data width
//   NREGS    number of registers (power of two, >= 2)
//   AW       address width, derived from NREGS (do not override)
//   NRD      number of read ports (1..4)
//   ZERO_REG 1: register 0 reads 0, ignores writes, never busy
//
// Ports (read port i occupies [i*AW +: AW] / [i*XLEN +: XLEN]):
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset; clears array, scoreboard, outputs
//   rd_en      per-port read enable; a disabled port holds its outputs
//   rd_addr    read addresses
//   rd_data    registered read data
//   rd_busy    registered: addressed register has a write pending
//   wen        writeback enable
//   addrW      writeback address
//   dataW      writeback data
//   issue_en   mark issue_addr as pending-write
//   issue_addr destination register of the issuing instruction
//   flush      clear every busy bit
// ---------------------------------------------------------------------------
module regfile_np #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wen,
    input  logic [AW-1:0]       addrW,
    input  logic [XLEN-1:0]     dataW,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr,
    input  logic                flush
);

    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_next;
    logic             wr_ok;

    // A write to the hardwired zero register is silently dropped.
    assign wr_ok = wen && !(HAS_ZERO && (addrW == '0));

    // -----------------------------------------------------------------------
    // Scoreboard next state. Priority: flush > issue set > writeback clear.
    // Issue wins over a same-cycle writeback because the newer instruction
    // now owns the destination register.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so every path drives busy_next and
        // no latch is inferred.
        busy_next = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            if (flush) begin
                busy_next[r] = 1'b0;
            end else if (issue_en && (issue_addr == AW'(r))) begin
                busy_next[r] = 1'b1;
            end else if (wen && (addrW == AW'(r))) begin
                busy_next[r] = 1'b0;
            end
        end
        if (HAS_ZERO) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of block ordering.
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    // -----------------------------------------------------------------------
    // Register array. Contents must read zero after reset, so the storage is
    // a flop array with a synchronous clear rather than an inferred RAM.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: resetting the whole array is deliberate -- no partial
            // state may survive a reset -- and rules out RAM mapping.
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[addrW] <= dataW;
        end
    end

    // -----------------------------------------------------------------------
    // Read ports: each port is fully independent. The read value is chosen
    // combinationally from the zero rule, the write-first bypass, and the
    // array, then registered; outputs therefore never depend combinationally
    // on any input.
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd_next;
        logic [XLEN-1:0] rd_data_q;
        logic            rd_busy_q;

        assign ra = rd_addr[i*AW +: AW];

        always_comb begin
            rd_next = regs[ra];
            if (HAS_ZERO && (ra == '0)) begin
                rd_next = '0;
            end else if (wen && (addrW == ra)) begin
                rd_next = dataW;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q <= '0;
                rd_busy_q <= 1'b0;
            end else if (rd_en[i]) begin
                rd_data_q <= rd_next;
                // Reflects this edge's own issue / writeback / flush.
                rd_busy_q <= busy_next[ra];
            end
        end

        assign rd_data[i*XLEN +: XLEN] = rd_data_q;
        assign rd_busy[i]              = rd_busy_q;
    end

endmodule

// File: tb/tb_regfile_np.sv
// ---------------------------------------------------------------------------
// tb_regfile_np -- self-checking bench for regfile_np.
//
// Two instances share clock and reset:
//   dut 0: defaults (XLEN=32, NREGS=32, NRD=2, ZERO_REG=1)
//   dut 1: XLEN=64, NREGS=16, NRD=4, ZERO_REG=0
// Each edge a reference model advances from the architectural rules (read old
// contents, bypass, then update the array and the pending-write set) and every
// port of both instances is compared after the edge.
// ---------------------------------------------------------------------------
module tb_regfile_np;

    logic clk;
    logic rst;

    // Stimulus, per dut (index 0/1), addresses as plain integers.
    bit          s_wen [2];
    int          s_wa  [2];
    logic [63:0] s_wd  [2];
    bit          s_ie  [2];
    int          s_ia  [2];
    bit          s_fl  [2];
    bit          s_re  [2][4];
    int          s_ra  [2][4];

    // Reference model state.
    logic [63:0] m_regs [2][32];
    bit          m_busy [2][32];
    logic [63:0] m_rd   [2][4];
    bit          m_rb   [2][4];

    int n_vec;
    int n_miss;

    // ---------------- dut 0 ----------------
    logic [1:0]  a_rd_en;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wen, a_issue_en, a_flush;
    logic [4:0]  a_addrW, a_issue_addr;
    logic [31:0] a_dataW;

    assign a_rd_en      = {s_re[0][1], s_re[0][0]};
    assign a_rd_addr    = {5'(s_ra[0][1]), 5'(s_ra[0][0])};
    assign a_wen        = s_wen[0];
    assign a_addrW      = 5'(s_wa[0]);
    assign a_dataW      = s_wd[0][31:0];
    assign a_issue_en   = s_ie[0];
    assign a_issue_addr = 5'(s_ia[0]);
    assign a_flush      = s_fl[0];

    regfile_np u_a (
        .clk(clk), .rst(rst),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr),
        .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wen(a_wen), .addrW(a_addrW), .dataW(a_dataW),
        .issue_en(a_issue_en), .issue_addr(a_issue_addr),
        .flush(a_flush)
    );

    // ---------------- dut 1 ----------------
    logic [3:0]   b_rd_en;
    logic [15:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic         b_wen, b_issue_en, b_flush;
    logic [3:0]   b_addrW, b_issue_addr;
    logic [63:0]  b_dataW;

    assign b_rd_en      = {s_re[1][3], s_re[1][2], s_re[1][1], s_re[1][0]};
    assign b_rd_addr    = {4'(s_ra[1][3]), 4'(s_ra[1][2]), 4'(s_ra[1][1]), 4'(s_ra[1][0])};
    assign b_wen        = s_wen[1];
    assign b_addrW      = 4'(s_wa[1]);
    assign b_dataW      = s_wd[1];
    assign b_issue_en   = s_ie[1];
    assign b_issue_addr = 4'(s_ia[1]);
    assign b_flush      = s_fl[1];

    regfile_np #(.XLEN(64), .NREGS(16), .NRD(4), .ZERO_REG(0)) u_b (
        .clk(clk), .rst(rst),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wen(b_wen), .addrW(b_addrW), .dataW(b_dataW),
        .issue_en(b_issue_en), .issue_addr(b_issue_addr),
        .flush(b_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- configuration helpers ----------------
    function automatic int nrd_of(int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic int nregs_of(int d);
        return (d == 0) ? 32 : 16;
    endfunction

    function automatic bit zero_of(int d);
        return (d == 0);
    endfunction

    function automatic logic [63:0] dmask(int d);
        return (d == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] got_data(int d, int k);
        if (d == 0) return 64'(a_rd_data[k*32 +: 32]);
        return b_rd_data[k*64 +: 64];
    endfunction

    function automatic bit got_busy(int d, int k);
        if (d == 0) return a_rd_busy[k];
        return b_rd_busy[k];
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            s_wen[d] = 0; s_wa[d] = 0; s_wd[d] = '0;
            s_ie[d]  = 0; s_ia[d] = 0; s_fl[d] = 0;
            for (int k = 0; k < 4; k++) begin
                s_re[d][k] = 0;
                s_ra[d][k] = 0;
            end
        end
    endtask

    task automatic rd(input int d, input int k, input int addr);
        s_re[d][k] = 1;
        s_ra[d][k] = addr & (nregs_of(d) - 1);
    endtask

    task automatic wr(input int d, input int addr, input logic [63:0] data);
        s_wen[d] = 1;
        s_wa[d]  = addr & (nregs_of(d) - 1);
        s_wd[d]  = data & dmask(d);
    endtask

    task automatic iss(input int d, input int addr);
        s_ie[d] = 1;
        s_ia[d] = addr & (nregs_of(d) - 1);
    endtask

    // ---------------- reference model ----------------
    // One edge of architectural behaviour: reads see the old contents except
    // for a same-edge write to the same address; the pending set is updated
    // in increasing priority (writeback clear, then issue set, then flush).
    task automatic model_edge(input int d);
        bit nb [32];
        int a;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[d][r] = '0;
                m_busy[d][r] = 0;
            end
            for (int k = 0; k < 4; k++) begin
                m_rd[d][k] = '0;
                m_rb[d][k] = 0;
            end
            return;
        end
        nb = m_busy[d];
        if (s_wen[d]) nb[s_wa[d]] = 0;
        if (s_ie[d])  nb[s_ia[d]] = 1;
        if (s_fl[d])  foreach (nb[r]) nb[r] = 0;
        if (zero_of(d)) nb[0] = 0;
        for (int k = 0; k < nrd_of(d); k++) begin
            if (s_re[d][k]) begin
                a = s_ra[d][k];
                if (zero_of(d) && a == 0)        m_rd[d][k] = '0;
                else if (s_wen[d] && s_wa[d] == a) m_rd[d][k] = s_wd[d];
                else                              m_rd[d][k] = m_regs[d][a];
                m_rb[d][k] = nb[a];
            end
        end
        if (s_wen[d] && !(zero_of(d) && s_wa[d] == 0)) m_regs[d][s_wa[d]] = s_wd[d];
        m_busy[d] = nb;
    endtask

    // Advance one clock and compare every port of both instances.
    task automatic step();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < nrd_of(d); k++) begin
                check($sformatf("dut%0d.p%0d.data", d, k), got_data(d, k), m_rd[d][k]);
                check($sformatf("dut%0d.p%0d.busy", d, k), 64'(got_busy(d, k)), 64'(m_rb[d][k]));
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        idle();
        @(negedge clk);

        // Reset, then read r5 / r31 on both ports.
        step();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin rd(d, 0, 5); rd(d, 1, 31); end
        step();
        check("reset.p0.data", got_data(0, 0), 64'h0);
        check("reset.p1.busy", 64'(got_busy(0, 1)), 64'h0);

        // Write then read next cycle.
        idle();
        for (int d = 0; d < 2; d++) wr(d, 3, 64'hDEAD_BEEF);
        step();
        idle();
        for (int d = 0; d < 2; d++) rd(d, 0, 3);
        step();
        check("wr_rd.r3", got_data(0, 0), 64'hDEAD_BEEF);

        // Same-edge bypass.
        idle();
        for (int d = 0; d < 2; d++) begin wr(d, 4, 64'h1234_5678); rd(d, 1, 4); end
        step();
        check("bypass.r4", got_data(0, 1), 64'h1234_5678);

        // Zero register: dut0 hardwired, dut1 ordinary.
        idle();
        for (int d = 0; d < 2; d++) wr(d, 0, 64'hFFFF_FFFF);
        step();
        idle();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < nrd_of(d); k++) rd(d, k, 0);
            iss(d, 0);
        end
        step();
        check("zero.p0.data", got_data(0, 0), 64'h0);
        check("zero.p1.data", got_data(0, 1), 64'h0);
        check("zero.p0.busy", 64'(got_busy(0, 0)), 64'h0);
        check("nozero.p3.data", got_data(1, 3), 64'hFFFF_FFFF);
        check("nozero.p0.busy", 64'(got_busy(1, 0)), 64'h1);

        // Scoreboard.
        idle();
        for (int d = 0; d < 2; d++) begin iss(d, 7); rd(d, 0, 7); end
        step();
        check("sb.issue.busy", 64'(got_busy(0, 0)), 64'h1);
        idle();
        for (int d = 0; d < 2; d++) begin wr(d, 7, 64'hA5); rd(d, 0, 7); end
        step();
        check("sb.wb.busy", 64'(got_busy(0, 0)), 64'h0);
        check("sb.wb.data", got_data(0, 0), 64'hA5);
        idle();
        for (int d = 0; d < 2; d++) begin iss(d, 7); wr(d, 7, 64'h1); rd(d, 0, 7); end
        step();
        check("sb.iss_wb.busy", 64'(got_busy(0, 0)), 64'h1);
        idle();
        for (int d = 0; d < 2; d++) begin s_fl[d] = 1; iss(d, 7); rd(d, 0, 7); end
        step();
        check("sb.flush.busy", 64'(got_busy(0, 0)), 64'h0);

        // Read-enable hold.
        idle();
        for (int d = 0; d < 2; d++) wr(d, 2, 64'h11);
        step();
        idle();
        for (int d = 0; d < 2; d++) rd(d, 0, 2);
        step();
        check("hold.read", got_data(0, 0), 64'h11);
        idle();
        for (int d = 0; d < 2; d++) begin s_ra[d][0] = 2; wr(d, 2, 64'h22); end
        step();
        check("hold.disabled", got_data(0, 0), 64'h11);
        idle();
        for (int d = 0; d < 2; d++) rd(d, 0, 2);
        step();
        check("hold.reenable", got_data(0, 0), 64'h22);

        // Random streams with occasional mid-stream reset.
        for (int n = 0; n < 1500; n++) begin
            idle();
            rst = ($urandom_range(0, 99) < 2);
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 1) != 0)
                    wr(d, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom,
                       {$urandom, $urandom});
                if ($urandom_range(0, 9) < 3)
                    iss(d, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom);
                s_fl[d] = ($urandom_range(0, 19) == 0);
                for (int k = 0; k < nrd_of(d); k++) begin
                    if ($urandom_range(0, 3) != 0)
                        rd(d, k, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom);
                    else
                        s_ra[d][k] = $urandom & (nregs_of(d) - 1);
                end
            end
            step();
        end

        // Final reset: every register and busy bit must read zero afterwards.
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int r = 0; r < 32; r++) begin
            idle();
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < nrd_of(d); k++) rd(d, k, r);
            step();
            check("post_reset.d1.p2.data", got_data(1, 2), 64'h0);
            check("post_reset.d0.p0.busy", 64'(got_busy(0, 0)), 64'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
